// File: rtl/median9_seq.sv
// median9_seq: serial 3x3 window median core.
// Loads 9 pixels, runs 5 bubble passes through one min/max stage.
module median9_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DSI,
  input  logic [WIDTH-1:0] DI,
  output logic [WIDTH-1:0] DO,
  output logic             DSO
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SORT,
    OUT
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       n_q, n_d;
  logic [2:0]       p_q, p_d;
  logic [2:0]       i_q, i_d;
  logic [WIDTH-1:0] r_q [9];
  logic [WIDTH-1:0] r_d [9];
  logic [WIDTH-1:0] do_q, do_d;
  logic             dso_q, dso_d;

  // next-state: load, compare-exchange step, result strobe
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    p_d     = p_q;
    i_d     = i_q;
    r_d     = r_q;
    do_d    = do_q;
    dso_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (DSI) begin
          r_d[0]  = DI;
          n_d     = 4'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (DSI) begin
          for (int k = 1; k < 9; k++) begin
            if (n_q == 4'(k)) r_d[k] = DI;
          end
          n_d = n_q + 4'd1;
          if (n_q == 4'd8) begin
            p_d     = 3'd0;
            i_d     = 3'd0;
            state_d = SORT;
          end
        end else begin
          n_d     = 4'd0;
          state_d = IDLE;
        end
      end
      SORT: begin
        for (int k = 0; k < 8; k++) begin
          if (i_q == 3'(k) && r_q[k] > r_q[k+1]) begin
            r_d[k]   = r_q[k+1];
            r_d[k+1] = r_q[k];
          end
        end
        if (i_q == 3'd7 - p_q) begin
          i_d = 3'd0;
          if (p_q == 3'd4) begin
            p_d     = 3'd0;
            state_d = OUT;
          end else begin
            p_d = p_q + 3'd1;
          end
        end else begin
          i_d = i_q + 3'd1;
        end
      end
      OUT: begin
        do_d    = r_q[4];
        dso_d   = 1'b1;
        n_d     = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      n_q     <= 4'd0;
      p_q     <= 3'd0;
      i_q     <= 3'd0;
      r_q     <= '{default: '0};
      do_q    <= '0;
      dso_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      p_q     <= p_d;
      i_q     <= i_d;
      r_q     <= r_d;
      do_q    <= do_d;
      dso_q   <= dso_d;
    end
  end

  assign DO  = do_q;
  assign DSO = dso_q;

endmodule

// File: tb/tb_median9_seq.sv
// tb_median9_seq: directed windows, abort, mid-sort reset,
// and random windows checked against a software median.
module tb_median9_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       DSI = 1'b0;
  logic [7:0] DI  = 8'd0;
  logic [7:0] DO;
  logic       DSO;

  median9_seq #(.WIDTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .DSI(DSI),
    .DI (DI),
    .DO (DO),
    .DSO(DSO)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [8:0][7:0] pix;
    logic [7:0]      exp;
  } vec_t;

  vec_t       vecs [4];
  int         total = 0;
  int         bad = 0;
  logic [7:0] prev_do = 8'd0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic logic [7:0] sw_median(input logic [8:0][7:0] pix);
    logic [7:0] a [9];
    logic [7:0] t;
    for (int k = 0; k < 9; k++) a[k] = pix[k];
    for (int x = 1; x < 9; x++) begin
      for (int y = x; y > 0; y--) begin
        if (a[y-1] > a[y]) begin
          t = a[y-1];
          a[y-1] = a[y];
          a[y] = t;
        end
      end
    end
    return a[4];
  endfunction

  // E0 is the first tick; DSO must be seen after tick 40 (E39).
  task automatic run_window(input logic [8:0][7:0] pix,
                            input logic [7:0] exp,
                            input string nm);
    int c;
    bit got;
    for (int k = 0; k < 9; k++) begin
      DSI = 1'b1;
      DI  = pix[k];
      tick();
      check({nm, "_load_dso"}, int'(DSO), 0);
      check({nm, "_load_do"}, int'(DO), int'(prev_do));
    end
    DSI = 1'b0;
    DI  = 8'hA5;
    c   = 9;
    got = 1'b0;
    while (!got && c < 80) begin
      DSI = c[0];
      tick();
      c++;
      if (DSO) got = 1'b1;
      else check({nm, "_hold_do"}, int'(DO), int'(prev_do));
    end
    DSI = 1'b0;
    if (got) begin
      check({nm, "_latency"}, c, 40);
      check({nm, "_do"}, int'(DO), int'(exp));
    end else begin
      check({nm, "_dso_timeout"}, 0, 1);
    end
    prev_do = exp;
  endtask

  initial begin
    logic [8:0][7:0] w;
    int bad0;

    for (int k = 0; k < 9; k++) begin
      vecs[0].pix[k] = 8'(k + 1);
      vecs[1].pix[k] = 8'(9 - k);
      vecs[2].pix[k] = 8'hFF;
      vecs[3].pix[k] = k[0] ? 8'd255 : 8'd0;
    end
    vecs[3].pix[8] = 8'd128;
    vecs[0].exp = 8'd5;
    vecs[1].exp = 8'd5;
    vecs[2].exp = 8'd255;
    vecs[3].exp = 8'd128;

    RST = 1'b1;
    tick();
    tick();
    check("reset_do", int'(DO), 0);
    check("reset_dso", int'(DSO), 0);
    RST = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      run_window(vecs[v].pix, vecs[v].exp, $sformatf("vec%0d", v));
    end
    tick();
    check("dso_one_cycle", int'(DSO), 0);

    for (int k = 0; k < 4; k++) begin
      DSI = 1'b1;
      DI  = 8'(200 + k);
      tick();
      check("abort_dso", int'(DSO), 0);
    end
    DSI = 1'b0;
    tick();
    check("abort_gap_dso", int'(DSO), 0);
    for (int k = 0; k < 9; k++) w[k] = 8'(10 * (k + 1));
    run_window(w, 8'd50, "abort_rewin");

    for (int k = 0; k < 9; k++) begin
      DSI = 1'b1;
      DI  = 8'(k + 1);
      tick();
    end
    DSI = 1'b0;
    for (int e = 9; e < 20; e++) begin
      tick();
      check("midsort_dso", int'(DSO), 0);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("midsort_rst_do", int'(DO), 0);
    check("midsort_rst_dso", int'(DSO), 0);
    prev_do = 8'd0;
    w = {8'd4, 8'd6, 8'd2, 8'd8, 8'd5, 8'd1, 8'd9, 8'd3, 8'd7};
    run_window(w, 8'd5, "post_rst");

    for (int r = 0; r < 1000; r++) begin
      for (int k = 0; k < 9; k++) w[k] = 8'($urandom_range(0, 255));
      bad0 = bad;
      run_window(w, sw_median(w), "rand");
      if (bad != bad0) break;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/median9_seq.md
# median9_seq

Sequential median-of-9 core for the 8-bit median filter datapath. It receives a 3×3 pixel window as a serial stream, one pixel per cycle. It finds the median by repeated compare-exchange through a single shared min/max stage, then presents the result with a one-cycle valid strobe. It consumes the pixel stream produced upstream of the median filter and feeds the filtered image writer.

## Interface
- WIDTH, 8, pixel width in bits (DI, DO, window registers)
- CLK  input  1  single clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset, sampled on CLK rising edge
- DSI  input  1  input strobe; high while DI carries a window pixel
- DI   input  WIDTH  pixel value, sampled when DSI=1 and the block is accepting
- DO   output WIDTH  median of last completed window; registered
- DSO  output 1  result strobe; high exactly one cycle per completed window

## Operation
- Storage: window registers R[0..8] (WIDTH bits each), one compare-exchange unit, pass counter p (0..4), step counter i (0..7), load counter n (0..9).
- FSM states: IDLE, LOAD, SORT, OUT.
- IDLE: if DSI=1, write R[0]<=DI, set n=1, go to LOAD. Otherwise stay.
- LOAD: if DSI=1, write R[n]<=DI and increment n. When the 9th pixel is written (n reaches 9), set p=0, i=0 and go to SORT.
- LOAD abort: if DSI=0 in LOAD before 9 samples, discard the partial window (n=0) and go to IDLE. DSO is not produced.
- SORT, one compare-exchange per cycle: R[i]<=min(R[i],R[i+1]), R[i+1]<=max(R[i],R[i+1]).
  - Equal operands are a legal tie; register contents are unchanged.
  - Pass p runs i=0..7-p. At the end of a pass, i resets to 0 and p increments.
  - After pass p, R[8-p] holds the (p+1)-th largest value.
  - After pass 4 (p=4, i=3), R[4] holds the median.
  - Step count: 8+7+6+5+4 = 30 steps.
- OUT: DO<=R[4], DSO<=1 for this one cycle, then go to IDLE.
- DSI is ignored in SORT and OUT. Pixels presented then are dropped and not buffered.
- DO holds its value until the next completed window; only DSO indicates a new result.
- Unsigned compare; no arithmetic widening needed.

## Timing
- Reset: RST=1 at an edge forces state=IDLE, n=p=i=0, all R=0, DO=0, DSO=0. This applies in any state, including mid-LOAD and mid-SORT; any result in progress is aborted and no DSO follows.
- Edge numbering: E0 = edge sampling the first pixel (DSI=1 in IDLE). Pixels are sampled at E0..E8, which requires DSI high for 9 consecutive cycles.
- SORT steps occur at E9..E38.
- OUT transition at E38; DO and DSO are updated at E39. DSO is high from E39 to E40.
- Latency from first pixel sample to DSO: 39 cycles. From last pixel: 31 cycles.
- Earliest next-window first pixel: E40 (block in IDLE after E39).
- Throughput: one window per 40 cycles, 41 if the source idles one cycle.
- DSO never asserts in two consecutive cycles.
- DSO=0 at all times except the single OUT-following cycle.

## Test plan
- Window 1,2,...,9 in order starting at E0:
  - DSO=1 only between E39 and E40.
  - DO=5 from E39 onward.
  - DO=0 and DSO=0 before E39 (after reset).
- Window 9,8,...,1 -> DO=5.
- Window all 0xFF -> DO=255.
- Window 0,255,0,255,0,255,0,255,128 -> DO=128. This covers tie handling and extremes.
- Abort and re-window: DSI high for 4 cycles (values 200,201,202,203), then low 1 cycle, then window 10,20,...,90:
  - exactly one DSO, 39 cycles after the sample of 10;
  - DO=50.
- Reset mid-SORT: RST=1 at E20 of a 1..9 window:
  - no DSO; DO=0;
  - a new window 7,3,9,1,5,8,2,6,4 presented immediately after reset gives DO=5 at its E39.
- Regression: 1000 back-to-back random windows, each compared against a software sort (5th smallest); the bench stops on the first mismatch.
